// File: rtl/extbus_arbiter.sv
// -----------------------------------------------------------------------------
// extbus_arbiter
//
// Owns the external asynchronous SRAM bus and shares it between three
// requesters: VPU video fetch (read-only), the CPU (external-region accesses)
// and a block-transfer DMA engine. Each granted transaction runs through
// IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE (1 cycle) -> IDLE, so there is
// always at least one IDLE cycle between transactions.
//
// Priority in IDLE is VPU > CPU > DMA, except that once the VPU has won
// VPU_BURST_MAX consecutive grants while the CPU was waiting, the CPU is
// forced in ahead of the VPU.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   cpu_req/rw/ad/do         CPU request, 1=read, 17-bit address, write data
//   cpu_di, cpu_hold         CPU read data, CPU stall (combinational)
//   vpu_req/ad               VPU fetch request and 16-bit address
//   vpu_data, vpu_ack        fetched byte, 1-cycle valid pulse
//   dma_req/rw/ad/do         DMA request, 1=read, 17-bit address, write data
//   dma_di, dma_ack          DMA read data, 1-cycle completion pulse
//   EXT_AD, EXT_DQ           SRAM address, bidirectional data (Z unless writing)
//   EXT_WE_n, EXT_OE_n       SRAM write strobe / output enable, active-low
//   SRAM_CS2                 SRAM chip select, active-high
// -----------------------------------------------------------------------------
module extbus_arbiter #(
  parameter int WAIT_STATES   = 1,  // 0..7
  parameter int VPU_BURST_MAX = 8   // 1..15
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [16:0] cpu_ad,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  output logic        cpu_hold,

  input  logic        vpu_req,
  input  logic [15:0] vpu_ad,
  output logic [7:0]  vpu_data,
  output logic        vpu_ack,

  input  logic        dma_req,
  input  logic        dma_rw,
  input  logic [16:0] dma_ad,
  input  logic [7:0]  dma_do,
  output logic [7:0]  dma_di,
  output logic        dma_ack,

  output logic [16:0] EXT_AD,
  inout  wire  [7:0]  EXT_DQ,
  output logic        EXT_WE_n,
  output logic        EXT_OE_n,
  output logic        SRAM_CS2
);

  localparam logic [2:0] LP_WAIT_LAST = 3'(WAIT_STATES);
  localparam logic [3:0] LP_BURST_MAX = 4'(VPU_BURST_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VPU,
    OWN_CPU,
    OWN_DMA
  } owner_t;

  // Transaction registers
  state_t      r_state;
  owner_t      r_owner;
  logic [16:0] r_addr;
  logic        r_rw;
  logic [7:0]  r_wdata;
  logic [2:0]  r_wait;
  logic [3:0]  r_burst;

  // Registered pin drivers and requester outputs
  logic        r_cs2;
  logic        r_oe_n;
  logic        r_we_n;
  logic        r_dq_oe;
  logic [7:0]  r_cpu_di;
  logic [7:0]  r_vpu_data;
  logic [7:0]  r_dma_di;
  logic        r_vpu_ack;
  logic        r_dma_ack;

  // Next-state values
  state_t      w_state_nxt;
  owner_t      w_owner_nxt;
  logic [16:0] w_addr_nxt;
  logic        w_rw_nxt;
  logic [7:0]  w_wdata_nxt;
  logic [2:0]  w_wait_nxt;
  logic [3:0]  w_burst_nxt;
  logic        w_latch_rd;
  logic        w_cpu_forced;
  logic [3:0]  w_burst_inc;

  // The CPU jumps the VPU once the burst allowance is used up.
  assign w_cpu_forced = cpu_req && (r_burst == LP_BURST_MAX);
  assign w_burst_inc  = (r_burst == LP_BURST_MAX) ? r_burst : r_burst + 4'd1;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_addr_nxt  = r_addr;
    w_rw_nxt    = r_rw;
    w_wdata_nxt = r_wdata;
    w_wait_nxt  = r_wait;
    w_burst_nxt = r_burst;
    w_latch_rd  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // A CPU-free IDLE cycle ends any VPU burst.
        if (!cpu_req) begin
          w_burst_nxt = 4'd0;
        end

        if (vpu_req && !w_cpu_forced) begin
          w_owner_nxt = OWN_VPU;
          w_addr_nxt  = {1'b0, vpu_ad};
          w_rw_nxt    = 1'b1;
          w_wdata_nxt = 8'h00;
          w_state_nxt = S_ACCESS;
          w_wait_nxt  = 3'd0;
          if (cpu_req) begin
            w_burst_nxt = w_burst_inc;
          end
        end else if (cpu_req) begin
          w_owner_nxt = OWN_CPU;
          w_addr_nxt  = cpu_ad;
          w_rw_nxt    = cpu_rw;
          w_wdata_nxt = cpu_do;
          w_state_nxt = S_ACCESS;
          w_wait_nxt  = 3'd0;
          w_burst_nxt = 4'd0;
        end else if (dma_req) begin
          w_owner_nxt = OWN_DMA;
          w_addr_nxt  = dma_ad;
          w_rw_nxt    = dma_rw;
          w_wdata_nxt = dma_do;
          w_state_nxt = S_ACCESS;
          w_wait_nxt  = 3'd0;
        end
      end

      S_ACCESS: begin
        if (r_wait == LP_WAIT_LAST) begin
          // The SRAM has had the full access window; capture read data now.
          w_latch_rd  = r_rw;
          w_state_nxt = S_DONE;
        end else begin
          w_wait_nxt = r_wait + 3'd1;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= OWN_NONE;
      r_addr     <= 17'd0;
      r_rw       <= 1'b1;
      r_wdata    <= 8'h00;
      r_wait     <= 3'd0;
      r_burst    <= 4'd0;
      r_cs2      <= 1'b0;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_dq_oe    <= 1'b0;
      r_cpu_di   <= 8'h00;
      r_vpu_data <= 8'h00;
      r_dma_di   <= 8'h00;
      r_vpu_ack  <= 1'b0;
      r_dma_ack  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_addr  <= w_addr_nxt;
      r_rw    <= w_rw_nxt;
      r_wdata <= w_wdata_nxt;
      r_wait  <= w_wait_nxt;
      r_burst <= w_burst_nxt;

      // Strobes are decoded from the next state so the pins are flop outputs
      // that change on the same edge as the state register.
      r_cs2   <= (w_state_nxt != S_IDLE);
      r_oe_n  <= !((w_state_nxt == S_ACCESS) && w_rw_nxt);
      r_we_n  <= !((w_state_nxt == S_ACCESS) && !w_rw_nxt);
      // Write data stays on the bus through DONE for SRAM hold time.
      r_dq_oe <= (w_state_nxt != S_IDLE) && !w_rw_nxt;

      r_vpu_ack <= (w_state_nxt == S_DONE) && (w_owner_nxt == OWN_VPU);
      r_dma_ack <= (w_state_nxt == S_DONE) && (w_owner_nxt == OWN_DMA);

      if (w_latch_rd) begin
        unique case (r_owner)
          OWN_VPU: r_vpu_data <= EXT_DQ;
          OWN_CPU: r_cpu_di   <= EXT_DQ;
          OWN_DMA: r_dma_di   <= EXT_DQ;
          default: ;
        endcase
      end
    end
  end

  // The CPU is released only in the DONE cycle of its own transaction.
  assign cpu_hold = cpu_req && !((r_state == S_DONE) && (r_owner == OWN_CPU));

  assign cpu_di   = r_cpu_di;
  assign vpu_data = r_vpu_data;
  assign vpu_ack  = r_vpu_ack;
  assign dma_di   = r_dma_di;
  assign dma_ack  = r_dma_ack;

  assign EXT_AD   = r_addr;
  assign EXT_WE_n = r_we_n;
  assign EXT_OE_n = r_oe_n;
  assign SRAM_CS2 = r_cs2;
  assign EXT_DQ   = r_dq_oe ? r_wdata : 8'bz;

endmodule

// File: tb/tb_extbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_extbus_arbiter
//
// Self-checking bench for extbus_arbiter. A behavioural SRAM sits on the
// external bus. The main instance uses WAIT_STATES=1, VPU_BURST_MAX=8; a
// second instance with WAIT_STATES=0 covers the zero-wait fetch latency.
// A bench-side driver (probe) puts a known byte on EXT_DQ when the DUT is
// expected to have released the bus; reading that byte back shows the DUT
// is not driving.
// -----------------------------------------------------------------------------
module tb_extbus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_req, cpu_rw;
  logic [16:0] cpu_ad;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_hold;
  logic        vpu_req;
  logic [15:0] vpu_ad;
  logic [7:0]  vpu_data;
  logic        vpu_ack;
  logic        dma_req, dma_rw;
  logic [16:0] dma_ad;
  logic [7:0]  dma_do;
  logic [7:0]  dma_di;
  logic        dma_ack;
  logic [16:0] ext_ad;
  wire  [7:0]  ext_dq;
  logic        ext_we_n, ext_oe_n, sram_cs2;

  // Zero-wait-state instance, VPU-only stimulus
  logic        v0_req;
  logic [15:0] v0_ad;
  logic [7:0]  v0_data;
  logic        v0_ack;
  logic [7:0]  z_cpu_di, z_dma_di;
  logic        z_cpu_hold, z_dma_ack;
  logic [16:0] ext_ad0;
  wire  [7:0]  ext_dq0;
  logic        ext_we_n0, ext_oe_n0, sram_cs20;

  // SRAM model, preload port and bus probe
  logic [7:0]  mem [0:131071];
  logic        ld_en;
  logic [16:0] ld_ad;
  logic [7:0]  ld_dat;
  logic        probe_en;
  localparam logic [7:0] PROBE = 8'h96;

  int n_checks = 0;
  int n_fail   = 0;

  extbus_arbiter #(.WAIT_STATES(1), .VPU_BURST_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_ad(cpu_ad), .cpu_do(cpu_do),
    .cpu_di(cpu_di), .cpu_hold(cpu_hold),
    .vpu_req(vpu_req), .vpu_ad(vpu_ad), .vpu_data(vpu_data), .vpu_ack(vpu_ack),
    .dma_req(dma_req), .dma_rw(dma_rw), .dma_ad(dma_ad), .dma_do(dma_do),
    .dma_di(dma_di), .dma_ack(dma_ack),
    .EXT_AD(ext_ad), .EXT_DQ(ext_dq), .EXT_WE_n(ext_we_n), .EXT_OE_n(ext_oe_n),
    .SRAM_CS2(sram_cs2)
  );

  extbus_arbiter #(.WAIT_STATES(0), .VPU_BURST_MAX(8)) dut0 (
    .clk(clk), .rst(rst),
    .cpu_req(1'b0), .cpu_rw(1'b1), .cpu_ad(17'd0), .cpu_do(8'h00),
    .cpu_di(z_cpu_di), .cpu_hold(z_cpu_hold),
    .vpu_req(v0_req), .vpu_ad(v0_ad), .vpu_data(v0_data), .vpu_ack(v0_ack),
    .dma_req(1'b0), .dma_rw(1'b1), .dma_ad(17'd0), .dma_do(8'h00),
    .dma_di(z_dma_di), .dma_ack(z_dma_ack),
    .EXT_AD(ext_ad0), .EXT_DQ(ext_dq0), .EXT_WE_n(ext_we_n0), .EXT_OE_n(ext_oe_n0),
    .SRAM_CS2(sram_cs20)
  );

  assign ext_dq  = (sram_cs2 && !ext_oe_n) ? mem[ext_ad] : 8'bz;
  assign ext_dq  = probe_en ? PROBE : 8'bz;
  assign ext_dq0 = (sram_cs20 && !ext_oe_n0) ? mem[ext_ad0] : 8'bz;

  always @(posedge clk) begin
    if (ld_en)                       mem[ld_ad]  <= ld_dat;
    else if (sram_cs2 && !ext_we_n)  mem[ext_ad] <= ext_dq;
  end

  typedef struct {
    logic        cpu_req;
    logic        cpu_rw;
    logic [16:0] cpu_ad;
    logic [7:0]  cpu_do;
    logic        hold;
    logic        oe_n;
    logic        we_n;
    logic        cs2;
    logic [16:0] ad;      // checked when cs2 is expected high
    int          dq_mode; // 0: ignore, 1: expect dq, 2: expect bus released
    logic [7:0]  dq;
    logic        chk_di;
    logic [7:0]  di;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic req, input logic rw, input logic [16:0] ad_in,
                              input logic [7:0] d_in, input logic hold, input logic oe_n,
                              input logic we_n, input logic cs2, input logic [16:0] ad,
                              input int dq_mode, input logic [7:0] dq,
                              input logic chk_di, input logic [7:0] di);
    vec_t v;
    v.cpu_req = req;  v.cpu_rw = rw;   v.cpu_ad = ad_in; v.cpu_do = d_in;
    v.hold    = hold; v.oe_n   = oe_n; v.we_n   = we_n;  v.cs2    = cs2;
    v.ad      = ad;   v.dq_mode = dq_mode; v.dq = dq;
    v.chk_di  = chk_di; v.di = di;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_ad = a; ld_dat = d;
    step();
    ld_en = 1'b0;
  endtask

  int t_v, t_c, t_d, nv, nc, nd;
  int nv_before, nv_between, ncdone;
  int nack, ncs;

  initial begin
    // Watchdog: never hang on a DUT event
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cpu_req = 0; cpu_rw = 1; cpu_ad = '0; cpu_do = '0;
    vpu_req = 0; vpu_ad = '0;
    dma_req = 0; dma_rw = 1; dma_ad = '0; dma_do = '0;
    v0_req = 0; v0_ad = '0;
    ld_en = 0; ld_ad = '0; ld_dat = '0; probe_en = 0;

    // CPU read: cycles 0..4
    vecs[0] = mk(1, 1, 17'h01234, 8'h00, 1, 1, 1, 0, 17'h0,     0, 8'h00, 0, 8'h00);
    vecs[1] = mk(1, 1, 17'h01234, 8'h00, 1, 0, 1, 1, 17'h01234, 0, 8'h00, 0, 8'h00);
    vecs[2] = mk(1, 1, 17'h01234, 8'h00, 1, 0, 1, 1, 17'h01234, 0, 8'h00, 0, 8'h00);
    vecs[3] = mk(1, 1, 17'h01234, 8'h00, 0, 1, 1, 1, 17'h01234, 0, 8'h00, 1, 8'h5A);
    vecs[4] = mk(0, 1, 17'h01234, 8'h00, 0, 1, 1, 0, 17'h0,     2, 8'h00, 1, 8'h5A);
    // CPU write of 0xA5 to 0x1E000; read data must survive the write
    vecs[5] = mk(1, 0, 17'h1E000, 8'hA5, 1, 1, 1, 0, 17'h0,     0, 8'h00, 0, 8'h00);
    vecs[6] = mk(1, 0, 17'h1E000, 8'hA5, 1, 1, 0, 1, 17'h1E000, 1, 8'hA5, 0, 8'h00);
    vecs[7] = mk(1, 0, 17'h1E000, 8'hA5, 1, 1, 0, 1, 17'h1E000, 1, 8'hA5, 0, 8'h00);
    vecs[8] = mk(1, 0, 17'h1E000, 8'hA5, 0, 1, 1, 1, 17'h1E000, 1, 8'hA5, 1, 8'h5A);
    vecs[9] = mk(0, 0, 17'h1E000, 8'hA5, 0, 1, 1, 0, 17'h0,     2, 8'h00, 1, 8'h5A);

    // ---- Reset state ----
    step();
    poke(17'h01234, 8'h5A);
    poke(17'h00400, 8'h3C);
    poke(17'h10055, 8'hC3);
    poke(17'h1E000, 8'h00);
    step();
    probe_en = 1; #1;
    check("rst_we_n",     ext_we_n, 1);
    check("rst_oe_n",     ext_oe_n, 1);
    check("rst_cs2",      sram_cs2, 0);
    check("rst_ad",       ext_ad,   0);
    check("rst_dq_z",     ext_dq,   PROBE);
    check("rst_vpu_ack",  vpu_ack,  0);
    check("rst_dma_ack",  dma_ack,  0);
    check("rst_cpu_di",   cpu_di,   0);
    check("rst_vpu_data", vpu_data, 0);
    check("rst_dma_di",   dma_di,   0);
    check("rst_cpu_hold", cpu_hold, 0);
    probe_en = 0;
    rst = 0;
    step();

    // ---- Table: CPU read then CPU write, one row per cycle ----
    for (int i = 0; i < 10; i++) begin
      cpu_req = vecs[i].cpu_req; cpu_rw = vecs[i].cpu_rw;
      cpu_ad  = vecs[i].cpu_ad;  cpu_do = vecs[i].cpu_do;
      probe_en = (vecs[i].dq_mode == 2);
      #1;
      check($sformatf("vec%0d_hold", i), cpu_hold, vecs[i].hold);
      check($sformatf("vec%0d_oe_n", i), ext_oe_n, vecs[i].oe_n);
      check($sformatf("vec%0d_we_n", i), ext_we_n, vecs[i].we_n);
      check($sformatf("vec%0d_cs2", i),  sram_cs2, vecs[i].cs2);
      if (vecs[i].cs2)          check($sformatf("vec%0d_ad", i), ext_ad, vecs[i].ad);
      if (vecs[i].dq_mode == 1) check($sformatf("vec%0d_dq", i), ext_dq, vecs[i].dq);
      if (vecs[i].dq_mode == 2) check($sformatf("vec%0d_dq_z", i), ext_dq, PROBE);
      if (vecs[i].chk_di)       check($sformatf("vec%0d_di", i), cpu_di, vecs[i].di);
      probe_en = 0;
      step();
    end
    check("write_mem", mem[17'h1E000], 8'hA5);

    // ---- Simultaneous requests: VPU, then CPU, then DMA ----
    vpu_req = 1; vpu_ad = 16'h0400;
    cpu_req = 1; cpu_rw = 1; cpu_ad = 17'h01234;
    dma_req = 1; dma_rw = 1; dma_ad = 17'h10055;
    t_v = -1; t_c = -1; t_d = -1; nv = 0; nc = 0; nd = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (vpu_ack) begin nv++; t_v = cyc; vpu_req = 0; end
      if (cpu_req && !cpu_hold) begin nc++; t_c = cyc; cpu_req = 0; end
      if (dma_ack) begin nd++; t_d = cyc; dma_req = 0; end
      step();
    end
    check("simul_vpu_cycle", t_v, 3);
    check("simul_cpu_cycle", t_c, 7);
    check("simul_dma_cycle", t_d, 11);
    check("simul_vpu_acks",  nv, 1);
    check("simul_cpu_dones", nc, 1);
    check("simul_dma_acks",  nd, 1);
    check("simul_vpu_data",  vpu_data, 8'h3C);
    check("simul_cpu_di",    cpu_di,   8'h5A);
    check("simul_dma_di",    dma_di,   8'hC3);

    // ---- VPU burst limit with CPU waiting ----
    vpu_req = 1; vpu_ad = 16'h0400;
    cpu_req = 1; cpu_rw = 1; cpu_ad = 17'h01234;
    nv_before = 0; nv_between = 0; ncdone = 0;
    for (int cyc = 0; cyc < 120 && ncdone < 2; cyc++) begin
      #1;
      if (vpu_ack) begin
        if (ncdone == 0) nv_before++;
        else             nv_between++;
      end
      if (cpu_req && !cpu_hold) ncdone++;
      step();
    end
    vpu_req = 0; cpu_req = 0;
    check("burst_cpu_dones",   ncdone, 2);
    check("burst_vpu_first",   nv_before, 8);
    check("burst_vpu_resumed", nv_between, 8);
    step();
    step();

    // ---- Reset during first ACCESS cycle of a DMA write ----
    dma_req = 1; dma_rw = 0; dma_ad = 17'h00777; dma_do = 8'h99;
    step();
    #1;
    check("abort_started_we_n", ext_we_n, 0);
    rst = 1; dma_req = 0;
    step();
    rst = 0; probe_en = 1; #1;
    check("abort_we_n", ext_we_n, 1);
    check("abort_cs2",  sram_cs2, 0);
    check("abort_dq_z", ext_dq,   PROBE);
    check("abort_ad",   ext_ad,   0);
    probe_en = 0;
    nack = 0; ncs = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step();
      #1;
      if (dma_ack)  nack++;
      if (sram_cs2) ncs++;
    end
    check("abort_no_dma_ack", nack, 0);
    check("abort_stays_idle", ncs, 0);

    // ---- Zero wait states: VPU read of 0x0400 ----
    v0_req = 1; v0_ad = 16'h0400;
    step();
    v0_req = 0; #1;   // request drops after grant; transaction must complete
    check("ws0_ad",        ext_ad0, 17'h00400);
    check("ws0_ad16",      ext_ad0[16], 0);
    check("ws0_oe_n",      ext_oe_n0, 0);
    check("ws0_ack_early", v0_ack, 0);
    step();
    check("ws0_ack",       v0_ack, 1);
    check("ws0_data",      v0_data, 8'h3C);
    step();
    check("ws0_ack_pulse", v0_ack, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/extbus_arbiter.md
Name: extbus_arbiter

Overview:
- Owns the external SRAM bus: EXT_AD, EXT_DQ, EXT_WE_n, EXT_OE_n and SRAM_CS2.
- Shares the bus between three requesters: VPU video fetch, the CPU (external-region accesses), and a block-transfer DMA requester.
- Runs a per-transaction FSM with programmable wait states.
- Stalls the CPU via cpu_hold until its access completes.
- Enforces a VPU burst limit so the CPU is never starved by video fetch.

Parameters:
- WAIT_STATES, 1, extra ACCESS cycles per transaction; ACCESS lasts WAIT_STATES+1 cycles (range 0..7).
- VPU_BURST_MAX, 8, max consecutive VPU grants while cpu_req is pending before the CPU is forced in (range 1..15).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cpu_req  in  1  CPU external access request (decoded external region AND vma).
- cpu_rw  in  1  1=read, 0=write.
- cpu_ad  in  17  CPU physical address, page bits already applied.
- cpu_do  in  8  CPU write data.
- cpu_di  out  8  CPU read data.
- cpu_hold  out  1  CPU clock-stall request.
- vpu_req  in  1  VPU fetch request (read-only).
- vpu_ad  in  16  VPU fetch address; EXT_AD[16] is forced to 0.
- vpu_data  out  8  fetched byte.
- vpu_ack  out  1  1-cycle pulse; vpu_data is valid.
- dma_req  in  1  DMA request.
- dma_rw  in  1  1=read, 0=write.
- dma_ad  in  17  DMA address.
- dma_do  in  8  DMA write data.
- dma_di  out  8  DMA read data.
- dma_ack  out  1  1-cycle completion pulse.
- EXT_AD  out  17  SRAM address.
- EXT_DQ  inout  8  SRAM data; Z unless writing.
- EXT_WE_n  out  1  write strobe, active-low.
- EXT_OE_n  out  1  output enable, active-low.
- SRAM_CS2  out  1  chip select, active-high.

Behaviour:
- Reset values (next edge with rst=1, regardless of state):
  - state=IDLE; EXT_WE_n=1, EXT_OE_n=1, SRAM_CS2=0, EXT_DQ=Z, EXT_AD=0.
  - vpu_ack=0, dma_ack=0; cpu_di, vpu_data, dma_di=0; burst counter=0; cpu_hold=0.
- FSM states IDLE, ACCESS, DONE:
  - IDLE: if any request is high, register the winner's owner id, address, rw and write data, clear wait counter, go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: SRAM_CS2=1 and EXT_AD=latched address.
    - Read: EXT_OE_n=0.
    - Write: EXT_WE_n=0 and EXT_DQ driven with latched data.
    - Stays WAIT_STATES+1 cycles. On the last cycle's edge, a read latches EXT_DQ into the owner's data register. Then go to DONE.
  - DONE (1 cycle): SRAM_CS2=1, address held, EXT_WE_n=1, EXT_OE_n=1. A write keeps EXT_DQ driven for hold time. Owner ack/done is high for this cycle only. Next state is IDLE.
- All bus strobes are registered outputs. No combinational paths from requests to pins.
- Priority in IDLE: VPU > CPU > DMA, with one exception.
  - If the burst counter equals VPU_BURST_MAX and cpu_req=1, the CPU wins over the VPU.
  - Burst counter: +1 on each VPU grant while cpu_req=1. Cleared on any CPU grant, and on any IDLE cycle where cpu_req=0. Saturates at VPU_BURST_MAX.
- cpu_hold = cpu_req AND NOT (state==DONE AND owner==CPU). This is the only combinational output.
  - cpu_ad, cpu_rw and cpu_do must be stable while held.
  - cpu_di stays valid from DONE until the next CPU read completes.
- Once granted, a transaction always completes, even if its request deasserts. It is aborted only by rst.
- Back-to-back requests: minimum spacing is one IDLE cycle between transactions.
- Latency from request high in IDLE to ack/done: WAIT_STATES+2 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep their requests asserted and receive no ack.

Test Plan:
- CPU read, WAIT_STATES=1, SRAM[0x01234]=0x5A, cpu_req rises in IDLE at cycle 0 -> cpu_hold=1 in cycles 0-2, OE_n=0 in cycles 1-2, cycle 3 cpu_hold=0 and cpu_di=0x5A.
- CPU write of 0xA5 to 0x1E000 -> WE_n low exactly 2 cycles, EXT_DQ=0xA5 for 3 cycles then Z, SRAM[0x1E000]=0xA5, OE_n stays 1.
- vpu_req, cpu_req and dma_req rise in the same cycle -> grants in order VPU, CPU, DMA; each ack occurs once; one IDLE cycle between transactions.
- vpu_req held high continuously with cpu_req=1, VPU_BURST_MAX=8 -> exactly 8 vpu_ack pulses, then the CPU transaction, then VPU grants resume with the counter cleared.
- rst asserted during the first ACCESS cycle of a DMA write -> next cycle WE_n=1, SRAM_CS2=0, EXT_DQ=Z, dma_ack never pulses, state=IDLE.
- WAIT_STATES=0, VPU read of 0x0400 (SRAM=0x3C) -> vpu_ack 2 cycles after request with vpu_data=0x3C and EXT_AD[16]=0.
